scancode_display_scheduler: RTL and testbench

//  Buffers PS/2 scan-code bytes from the keyboard receiver and filters break
//  (F0) and extended (E0) sequences. Schedules make codes onto the 4-digit

---
 rtl/scancode_display_scheduler.sv | 232 +++++++++++++++++++++++
 tb/tb_scancode_display_scheduler.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scancode_display_scheduler.sv
// Scan-code filter, FIFO and dwell-paced shifter for the 4-digit display.
// Make codes are queued and shifted into disp_val no faster than one per dwell.
module scancode_display_scheduler #(
    parameter int FIFO_DEPTH   = 4,
    parameter int DWELL_CYCLES = 10_000_000
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [7:0]                  code_in,
    input  logic                        code_valid,
    input  logic                        clear,
    output logic [31:0]                 disp_val,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow,
    output logic                        busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    localparam logic [AW:0]   FULL_CNT   = (AW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);

    localparam logic [7:0] BRK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE = 8'hE0;

    typedef enum logic [1:0] {
        F_IDLE,
        F_BRK,
        F_EXT,
        F_EXTBRK
    } filt_e;

    typedef enum logic {
        S_READY,
        S_DWELL
    } sched_e;

    // Reset and clear share one flush path; both are synchronous.
    logic flush;
    assign flush = !reset_n || clear;

    filt_e  filt_q, filt_d;
    sched_e sched_q, sched_d;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   disp_q, disp_d;
    logic [CW-1:0] dwell_q, dwell_d;

    logic push;
    logic pop;
    logic full;
    logic do_push;
    logic [7:0] head;

    // ---------------- filter FSM ----------------

    // Filter state register.
    always_ff @(posedge clk) begin
        if (flush) begin
            filt_q <= F_IDLE;
        end else begin
            filt_q <= filt_d;
        end
    end

    // Filter next state: swallow break and extended sequences.
    always_comb begin
        filt_d = filt_q;
        if (code_valid) begin
            unique case (filt_q)
                F_IDLE: begin
                    if (code_in == BRK_CODE) begin
                        filt_d = F_BRK;
                    end else if (code_in == EXT_CODE) begin
                        filt_d = F_EXT;
                    end else begin
                        filt_d = F_IDLE;
                    end
                end
                F_BRK: begin
                    filt_d = F_IDLE;
                end
                F_EXT: begin
                    if (code_in == BRK_CODE) begin
                        filt_d = F_EXTBRK;
                    end else begin
                        filt_d = F_IDLE;
                    end
                end
                F_EXTBRK: begin
                    filt_d = F_IDLE;
                end
            endcase
        end
    end

    // Filter output: only plain make codes seen in idle are queued.
    always_comb begin
        push = 1'b0;
        if (code_valid && (filt_q == F_IDLE) &&
            (code_in != BRK_CODE) && (code_in != EXT_CODE)) begin
            push = 1'b1;
        end
    end

    // ---------------- scheduler FSM ----------------

    // Scheduler state register.
    always_ff @(posedge clk) begin
        if (flush) begin
            sched_q <= S_READY;
        end else begin
            sched_q <= sched_d;
        end
    end

    // Scheduler next state: shift when a code waits, then hold for the dwell.
    always_comb begin
        sched_d = sched_q;
        unique case (sched_q)
            S_READY: begin
                if (count_q != '0) begin
                    sched_d = S_DWELL;
                end
            end
            S_DWELL: begin
                if (dwell_q == DWELL_LAST) begin
                    sched_d = S_READY;
                end
            end
        endcase
    end

    // Scheduler outputs: pop only from a non-empty FIFO while ready.
    always_comb begin
        pop  = 1'b0;
        busy = 1'b0;
        unique case (sched_q)
            S_READY: begin
                pop = (count_q != '0);
            end
            S_DWELL: begin
                busy = 1'b1;
            end
        endcase
    end

    // ---------------- FIFO ----------------

    assign full    = (count_q == FULL_CNT);
    assign do_push = push && (!full || pop);
    assign head    = mem_q[rd_ptr_q];

    // FIFO pointer, count and sticky overflow next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({do_push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
        if (push && full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    // FIFO control registers.
    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO storage; contents are don't-care once pointers are flushed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= code_in;
        end
    end

    // ---------------- display and dwell ----------------

    // Display and dwell counter next state.
    always_comb begin
        disp_d  = disp_q;
        dwell_d = dwell_q;
        if (pop) begin
            disp_d  = {disp_q[23:0], head};
            dwell_d = '0;
        end else if (sched_q == S_DWELL) begin
            dwell_d = dwell_q + CW'(1);
        end
    end

    // Display shift register and dwell counter.
    always_ff @(posedge clk) begin
        if (flush) begin
            disp_q  <= '0;
            dwell_q <= '0;
        end else begin
            disp_q  <= disp_d;
            dwell_q <= dwell_d;
        end
    end

    assign disp_val   = disp_q;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_scancode_display_scheduler.sv
// Bench for scancode_display_scheduler: queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_scancode_display_scheduler;

    localparam int DEPTH = 4;
    localparam int DWELL = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  code_in = 8'h00;
    logic        code_valid = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] disp_val;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic        busy;

    int pass_cnt = 0;
    int total_cnt = 0;
    bit chk_en = 1'b0;

    scancode_display_scheduler #(
        .FIFO_DEPTH(DEPTH),
        .DWELL_CYCLES(DWELL)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .code_in(code_in),
        .code_valid(code_valid),
        .clear(clear),
        .disp_val(disp_val),
        .fifo_count(fifo_count),
        .overflow(overflow),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model state.
    logic [7:0]  q[$];
    logic [31:0] m_disp = '0;
    bit          m_ovf = 1'b0;
    bit          m_busy = 1'b0;
    bit          after_f0 = 1'b0;
    bit          after_e0 = 1'b0;
    bit          have_shift = 1'b0;
    int          edge_n = 0;
    int          last_shift = 0;
    bit          ready;
    bit          do_pop;
    int          sz;
    logic [7:0]  head;

    // Model: shifts are allowed DWELL+1 edges after the previous one,
    // break/extended prefixes swallow the following byte(s).
    initial begin
        forever begin
            @(posedge clk);
            edge_n++;
            if (!reset_n || clear) begin
                q.delete();
                m_disp = '0;
                m_ovf = 1'b0;
                after_f0 = 1'b0;
                after_e0 = 1'b0;
                have_shift = 1'b0;
            end else begin
                ready = !have_shift || (edge_n - last_shift >= DWELL + 1);
                sz = q.size();
                do_pop = ready && (sz != 0);
                if (do_pop) begin
                    head = q.pop_front();
                    m_disp = {m_disp[23:0], head};
                    last_shift = edge_n;
                    have_shift = 1'b1;
                end
                if (code_valid) begin
                    if (after_e0) begin
                        after_e0 = 1'b0;
                        if (code_in == 8'hF0) after_f0 = 1'b1;
                    end else if (after_f0) begin
                        after_f0 = 1'b0;
                    end else if (code_in == 8'hF0) begin
                        after_f0 = 1'b1;
                    end else if (code_in == 8'hE0) begin
                        after_e0 = 1'b1;
                    end else if (sz < DEPTH || do_pop) begin
                        q.push_back(code_in);
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
            m_busy = have_shift && (edge_n - last_shift < DWELL);
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("model disp_val", disp_val, m_disp);
                check("model fifo_count", 32'(fifo_count), 32'(q.size()));
                check("model overflow", 32'(overflow), 32'(m_ovf));
                check("model busy", 32'(busy), 32'(m_busy));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] b);
        code_in = b;
        code_valid = 1'b1;
        @(posedge clk);
        #1;
        code_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    initial begin
        step(2);
        reset_n = 1'b1;
        chk_en = 1'b1;
        check("reset disp", disp_val, 32'h0);
        check("reset count", 32'(fifo_count), 32'd0);
        check("reset ovf", 32'(overflow), 32'd0);
        check("reset busy", 32'(busy), 32'd0);

        // 1: single code, one-edge latency, four busy cycles
        strobe(8'h16);
        check("t1 disp at E", disp_val, 32'h0);
        step(1);
        check("t1 disp at E+1", disp_val, 32'h0000_0016);
        check("t1 busy at E+1", 32'(busy), 32'd1);
        step(3);
        check("t1 busy at E+4", 32'(busy), 32'd1);
        step(1);
        check("t1 busy at E+5", 32'(busy), 32'd0);

        // 2: break sequence filtered
        do_clear();
        strobe(8'h16);
        strobe(8'hF0);
        strobe(8'h16);
        step(12);
        check("t2 disp", disp_val, 32'h0000_0016);
        check("t2 count", 32'(fifo_count), 32'd0);
        check("t2 ovf", 32'(overflow), 32'd0);

        // 3: extended make and extended break filtered
        do_clear();
        strobe(8'hE0);
        strobe(8'h75);
        strobe(8'hE0);
        strobe(8'hF0);
        strobe(8'h75);
        step(8);
        check("t3 disp", disp_val, 32'h0);
        check("t3 count", 32'(fifo_count), 32'd0);
        strobe(8'h22);
        step(1);
        check("t3 idle after ext", disp_val, 32'h0000_0022);

        // 4: burst overfills the FIFO
        do_clear();
        strobe(8'h45);
        strobe(8'h16);
        check("t4 first shown", disp_val, 32'h0000_0045);
        strobe(8'h1E);
        strobe(8'h26);
        strobe(8'h25);
        check("t4 ovf before drop", 32'(overflow), 32'd0);
        check("t4 count full", 32'(fifo_count), 32'd4);
        strobe(8'h2E);
        check("t4 ovf", 32'(overflow), 32'd1);
        step(20);
        check("t4 final disp", disp_val, 32'h161E_2625);
        check("t4 final count", 32'(fifo_count), 32'd0);
        check("t4 ovf sticky", 32'(overflow), 32'd1);

        // 5: clear during dwell with codes queued
        do_clear();
        strobe(8'h11);
        strobe(8'h12);
        strobe(8'h13);
        check("t5 queued", 32'(fifo_count), 32'd2);
        check("t5 busy", 32'(busy), 32'd1);
        do_clear();
        check("t5 disp", disp_val, 32'h0);
        check("t5 count", 32'(fifo_count), 32'd0);
        check("t5 busy clr", 32'(busy), 32'd0);
        check("t5 ovf", 32'(overflow), 32'd0);
        strobe(8'h1C);
        step(1);
        check("t5 next code", disp_val, 32'h0000_001C);

        // 6: clear beats code_valid; reset clears filter state
        step(6);
        clear = 1'b1;
        code_in = 8'h44;
        code_valid = 1'b1;
        step(1);
        clear = 1'b0;
        code_valid = 1'b0;
        check("t6 count", 32'(fifo_count), 32'd0);
        step(3);
        check("t6 disp", disp_val, 32'h0);
        strobe(8'hE0);
        strobe(8'hF0);
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        strobe(8'h33);
        step(1);
        check("t6 after reset", disp_val, 32'h0000_0033);
        step(8);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
